spi_bus_scheduler: RTL and testbench

//  Shares one SPI bus between NUM_REQ requesters and sequences each transfer.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sclk_gen.sv | 43 ++++
 rtl/spi_bus_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_spi_bus_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI bus scheduler.
// State encoding, SPI mode 0 constants and the requester-id width helper.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles every CLK_DIV cycles while enabled.
// Strobes mark the clk edge on which sclk leaves/returns to its idle level.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            sclk <= SPI_CPOL;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= SPI_CPOL;
        end else if (wrap) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

    always_comb begin
        rise_stb = en && wrap && (sclk == SPI_CPOL);
        fall_stb = en && wrap && (sclk != SPI_CPOL);
    end

endmodule

// File: rtl/spi_bus_scheduler.sv
// Round-robin SPI bus scheduler: arbitrates NUM_REQ clients onto one
// mode-0 SPI bus and runs a full-duplex DATA_W-bit exchange per grant.
module spi_bus_scheduler
    import spi_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2,
    localparam int IW     = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      abort,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [IW-1:0]             rsp_id,
    output logic                      busy,
    output logic                      sclk,
    output logic                      mosi,
    input  logic                      miso,
    output logic [NUM_REQ-1:0]        cs_n
);

    localparam int BW   = $clog2(DATA_W + 1);
    localparam int TMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int TW   = $clog2(TMAX + 1);

    spi_state_t        state;
    spi_state_t        state_nxt;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     gnt_id;
    logic [IW-1:0]     arb_id;
    logic [IW-1:0]     enc;
    logic [NUM_REQ-1:0] rot;
    logic              arb_any;
    logic              grant;
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] rx;
    logic [BW-1:0]     bit_cnt;
    logic [TW-1:0]     tmr;
    logic              div_hit;
    logic              gap_hit;
    logic              last_fall;
    logic              active;
    logic              end_xfer;
    logic              hold_done;
    logic              sclk_en;
    logic              rise_stb;
    logic              fall_stb;

    function automatic logic [IW-1:0] mod_add(input int a, input int b);
        int s;
        s = a + b;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    // Rotate so rr_ptr sits at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        rot     = '0;
        enc     = '0;
        arb_any = |req_valid;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = req_valid[mod_add(i, int'(rr_ptr))];
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) enc = IW'(i);
        end
        arb_id = mod_add(int'(enc), int'(rr_ptr));
    end

    assign grant     = (state == ST_IDLE) && arb_any;
    assign active    = (state == ST_SETUP) || (state == ST_SHIFT) ||
                       (state == ST_HOLD);
    assign div_hit   = (tmr == TW'(CLK_DIV - 1));
    assign gap_hit   = (tmr == TW'(CS_GAP - 1));
    assign last_fall = fall_stb && (bit_cnt == BW'(DATA_W - 1));
    assign hold_done = (state == ST_HOLD) && div_hit && !abort;
    assign end_xfer  = (active && abort) || hold_done;
    assign sclk_en   = (state == ST_SHIFT) && !abort;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk (
        .clk      (clk),
        .reset    (reset),
        .en       (sclk_en),
        .sclk     (sclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state == ST_IDLE ||
                state == ST_SHIFT) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + 1'b1;
            end
        end
    end

    // abort outranks every normal exit, including the end of HOLD.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (arb_any) state_nxt = ST_SETUP;
            ST_SETUP: begin
                if (abort)        state_nxt = ST_GAP;
                else if (div_hit) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (abort)          state_nxt = ST_GAP;
                else if (last_fall) state_nxt = ST_HOLD;
            end
            ST_HOLD:  if (abort || div_hit) state_nxt = ST_GAP;
            ST_GAP:   if (gap_hit) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            gnt_id    <= '0;
            tx        <= '0;
            rx        <= '0;
            bit_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (grant) begin
                gnt_id  <= arb_id;
                tx      <= req_data[arb_id*DATA_W +: DATA_W];
                rx      <= '0;
                bit_cnt <= '0;
            end
            if (rise_stb) begin
                rx <= {rx[DATA_W-2:0], miso};
            end
            if (fall_stb) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (!last_fall) tx <= tx << 1;
            end
            if (hold_done) begin
                rsp_valid <= 1'b1;
                rsp_data  <= rx;
                rsp_id    <= gnt_id;
            end
            if (end_xfer) begin
                rr_ptr <= mod_add(int'(gnt_id), 1);
            end
        end
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        cs_n      = '1;
        mosi      = 1'b0;
        req_ready = '0;
        if (active) begin
            cs_n[gnt_id] = 1'b0;
            mosi         = tx[DATA_W-1];
        end
        if (grant && !reset) begin
            req_ready[arb_id] = 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_bus_scheduler.sv
// Directed bench for spi_bus_scheduler at default parameters.
// Covers single transfer, round-robin, loopback, abort, async reset, withdrawal.
module tb_spi_bus_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        abort;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic [3:0]  cs_n;

    logic        loop;
    logic [7:0]  slv_pat;
    int          f0;
    int          rise_cnt;
    int          fall_cnt;
    logic [7:0]  mosi_log;
    int          hi_run;
    int          last_gap;
    bit          seen_lo;
    int          bad_cs;
    int          bad_sclk;
    int          ready2_cnt;

    int          n_chk;
    int          n_fail;

    spi_bus_scheduler u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .abort     (abort),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .cs_n      (cs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: presents pattern MSB first, advancing after each fall.
    assign miso = loop ? mosi : slv_pat[3'(7 - (fall_cnt - f0))];

    initial begin
        rise_cnt = 0;
        fall_cnt = 0;
        mosi_log = '0;
    end

    always @(posedge sclk) begin
        rise_cnt = rise_cnt + 1;
        mosi_log = {mosi_log[6:0], mosi};
    end

    always @(negedge sclk) fall_cnt = fall_cnt + 1;

    initial begin
        hi_run     = 0;
        last_gap   = 0;
        seen_lo    = 1'b0;
        bad_cs     = 0;
        bad_sclk   = 0;
        ready2_cnt = 0;
    end

    always @(negedge clk) begin
        if (&cs_n) begin
            hi_run = hi_run + 1;
        end else begin
            if (seen_lo && hi_run > 0) last_gap = hi_run;
            hi_run  = 0;
            seen_lo = 1'b1;
            if (!$onehot(~cs_n)) bad_cs = bad_cs + 1;
        end
        if (sclk && (&cs_n)) bad_sclk = bad_sclk + 1;
        if (req_ready[2]) ready2_cnt = ready2_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] oh_idx(input logic [3:0] v);
        oh_idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) oh_idx = 4'(i);
        end
    endfunction

    task automatic wait_rsp(input int max, output int cyc);
        cyc = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic send(input logic [3:0] rv, input bit hold,
                        output logic [3:0] gnt);
        gnt = '0;
        @(negedge clk);
        req_valid = rv;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (|req_ready) begin
                gnt = req_ready;
                break;
            end
            @(negedge clk);
        end
        if (gnt == '0) chk("send_timeout", 32'(req_ready), 32'(rv));
        @(negedge clk);
        if (!hold) req_valid = '0;
    endtask

    int         cyc;
    int         r0;
    int         nrsp;
    int         nr;
    int         rd0;
    logic [3:0] gnt;
    logic [19:0] gseq;
    logic [19:0] rseq;

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        abort     = 1'b0;
        loop      = 1'b0;
        slv_pat   = '0;
        f0        = 0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cs_n", 32'(cs_n), 32'hF);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        reset = 1'b0;

        // Single transfer, slave returns 8'h3C
        @(negedge clk);
        slv_pat        = 8'h3C;
        f0             = fall_cnt;
        r0             = rise_cnt;
        req_data[15:8] = 8'hA5;
        req_valid      = 4'b0010;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h2);
        chk("t1_busy_idle", 32'(busy), 32'd0);
        cyc = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("t1_cs_n", 32'(cs_n), 32'hD);
                chk("t1_mosi_setup", 32'(mosi), 32'd1);
                chk("t1_busy", 32'(busy), 32'd1);
                req_valid = '0;
            end
            if (rsp_valid) begin
                cyc = i;
                break;
            end
        end
        chk("t1_latency", 32'(cyc), 32'd37);
        chk("t1_rsp_data", 32'(rsp_data), 32'h3C);
        chk("t1_rsp_id", 32'(rsp_id), 32'd1);
        chk("t1_mosi_bits", 32'(mosi_log), 32'hA5);
        chk("t1_rises", 32'(rise_cnt - r0), 32'd8);
        chk("t1_cs_off", 32'(cs_n), 32'hF);
        @(negedge clk);
        chk("t1_rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("t1_rsp_hold", 32'(rsp_data), 32'h3C);

        // Round-robin with all requesters held high
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        loop      = 1'b1;
        req_data  = 32'h44332211;
        req_valid = 4'hF;
        gseq      = '0;
        rseq      = '0;
        nrsp      = 0;
        for (int i = 0; i < 400 && nrsp < 5; i++) begin
            #1;
            if (|req_ready) gseq = {gseq[15:0], oh_idx(req_ready)};
            if (rsp_valid) begin
                rseq = {rseq[15:0], 2'b00, rsp_id};
                nrsp = nrsp + 1;
                if (nrsp == 5) req_valid = '0;
            end
            @(negedge clk);
        end
        chk("t2_rsp_count", 32'(nrsp), 32'd5);
        chk("t2_grant_order", 32'(gseq), 32'h01230);
        chk("t2_rsp_order", 32'(rseq), 32'h01230);
        chk("t2_last_data", 32'(rsp_data), 32'h11);
        chk("t2_cs_gap", 32'(last_gap), 32'd3);

        // Loopback 8'hFF then 8'h00
        req_data[31:24] = 8'hFF;
        r0 = rise_cnt;
        send(4'b1000, 1'b0, gnt);
        chk("t3_gnt", 32'(gnt), 32'h8);
        wait_rsp(60, cyc);
        chk("t3_ff_data", 32'(rsp_data), 32'hFF);
        chk("t3_ff_rises", 32'(rise_cnt - r0), 32'd8);
        req_data[31:24] = 8'h00;
        r0 = rise_cnt;
        send(4'b1000, 1'b0, gnt);
        wait_rsp(60, cyc);
        chk("t3_00_data", 32'(rsp_data), 32'h00);
        chk("t3_00_rises", 32'(rise_cnt - r0), 32'd8);

        // Abort at the 3rd rising edge of SHIFT
        req_data[23:16] = 8'h5A;
        req_data[31:24] = 8'hC3;
        send(4'b1100, 1'b1, gnt);
        chk("t4_first_gnt", 32'(gnt), 32'h4);
        r0 = rise_cnt;
        for (int i = 0; i < 40; i++) begin
            if (rise_cnt - r0 == 3) break;
            @(negedge clk);
        end
        chk("t4_in_shift", 32'(sclk), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_cs_n", 32'(cs_n), 32'hF);
        chk("t4_sclk", 32'(sclk), 32'd0);
        chk("t4_mosi", 32'(mosi), 32'd0);
        nr  = 0;
        gnt = '0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) nr = nr + 1;
            if (|req_ready) begin
                gnt = req_ready;
                break;
            end
            @(negedge clk);
        end
        chk("t4_no_rsp", 32'(nr), 32'd0);
        chk("t4_next_gnt", 32'(gnt), 32'h8);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(60, cyc);
        chk("t4_rsp_id", 32'(rsp_id), 32'd3);
        chk("t4_rsp_data", 32'(rsp_data), 32'hC3);

        // Reset mid-SHIFT with rr_ptr advanced to 3
        req_data[23:16] = 8'h96;
        send(4'b0100, 1'b0, gnt);
        wait_rsp(60, cyc);
        chk("t5_pre_data", 32'(rsp_data), 32'h96);
        req_data[15:8] = 8'h4B;
        send(4'b0010, 1'b0, gnt);
        chk("t5_pre_gnt", 32'(gnt), 32'h2);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_cs_n", 32'(cs_n), 32'hF);
        chk("t5_sclk", 32'(sclk), 32'd0);
        chk("t5_mosi", 32'(mosi), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_rsp_data", 32'(rsp_data), 32'd0);
        chk("t5_rsp_id", 32'(rsp_id), 32'd0);
        req_valid = 4'b1010;
        #1;
        chk("t5_ready_in_rst", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5_gnt_from0", 32'(req_ready), 32'h2);
        rd0 = ready2_cnt;
        @(negedge clk);
        req_valid = '0;

        // Withdrawn request while busy
        repeat (4) @(negedge clk);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(60, cyc);
        chk("t6_rsp_id", 32'(rsp_id), 32'd1);
        chk("t6_rsp_data", 32'(rsp_data), 32'h4B);
        repeat (6) @(negedge clk);
        chk("t6_no_ready2", 32'(ready2_cnt - rd0), 32'd0);
        chk("t6_idle", 32'(busy), 32'd0);

        chk("cs_onehot", 32'(bad_cs), 32'd0);
        chk("sclk_gated", 32'(bad_sclk), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
